// File: rtl/instruction_loader_if.sv
// Byte-stream and memory-write bundle for the boot-time instruction loader.
// Latency: none, wires only.
// Backpressure: InReady qualifies InValid; the memory write side cannot stall.
interface instruction_loader_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              Start;
    logic [7:0]        InByte;
    logic              InValid;
    logic              InReady;
    logic              WrEn;
    logic [ADDR_W-1:0] WrAddr;
    logic [7:0]        WrData;
    logic              Busy;
    logic              Done;
    logic              Error;
    logic              CpuHold;
    logic [15:0]       WordCount;

    // Host / debug side that sources the framed byte stream.
    modport master (
        output Start, InByte, InValid,
        input  InReady, WrEn, WrAddr, WrData, Busy, Done, Error, CpuHold, WordCount
    );

    // Loader side.
    modport slave (
        input  Start, InByte, InValid,
        output InReady, WrEn, WrAddr, WrData, Busy, Done, Error, CpuHold, WordCount
    );
endinterface

// File: rtl/instruction_loader.sv
// Boot loader: takes a LEN_HI/LEN_LO/payload/CSUM frame and writes payload bytes big-endian into imem.
// Latency: one cycle from an accepted payload byte to its WrEn pulse; status one cycle after CSUM.
// Backpressure: InReady is high in every frame-receiving state; the loader never stalls mid-frame.
module instruction_loader #(
    parameter int unsigned MEM_BYTES = 100,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic                CLK,
    input  logic                Reset,
    instruction_loader_if.slave bus
);

    // Wide enough that BASE_ADDR + 4*len can never wrap.
    localparam int unsigned EW = ADDR_W + 19;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q;
    logic [15:0]       word_count_q;
    logic [7:0]        csum_q;
    logic [17:0]       idx_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;
    logic              done_q;
    logic              error_q;
    logic              cpu_hold_q;

    logic              in_ready_d;
    logic              xfer_d;
    logic [15:0]       len_d;
    logic [EW-1:0]     end_d;
    logic [17:0]       last_idx_d;

    assign in_ready_d = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                        (state_q == S_DATA)   || (state_q == S_CSUM);
    assign xfer_d     = bus.InValid && in_ready_d;
    // Full length as it will be once the LEN_LO byte lands.
    assign len_d      = {word_count_q[15:8], bus.InByte};
    assign end_d      = EW'(BASE_ADDR) + EW'({len_d, 2'b00});
    assign last_idx_d = {word_count_q, 2'b00} - 18'd1;

    // Frame-parsing state machine; all status and write-port outputs are registered here.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            word_count_q <= '0;
            csum_q       <= '0;
            idx_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cpu_hold_q   <= 1'b1;
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (bus.Start) begin
                        state_q    <= S_LEN_HI;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        csum_q     <= '0;
                        idx_q      <= '0;
                        cpu_hold_q <= 1'b1;
                    end
                end
                S_LEN_HI: begin
                    if (xfer_d) begin
                        word_count_q[15:8] <= bus.InByte;
                        state_q            <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (xfer_d) begin
                        word_count_q[7:0] <= bus.InByte;
                        if (len_d == 16'd0) begin
                            state_q <= S_CSUM;
                        end else if (end_d > EW'(MEM_BYTES)) begin
                            // Frame would overrun the array: refuse before any byte is written.
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer_d) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q);
                        wr_data_q <= bus.InByte;
                        csum_q    <= csum_q ^ bus.InByte;
                        idx_q     <= idx_q + 18'd1;
                        if (idx_q == last_idx_d) begin
                            state_q <= S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (xfer_d) begin
                        if (bus.InByte == csum_q) begin
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.InReady   = in_ready_d;
    // The last WrEn pulse overlaps the CSUM state, but keep Busy tied to it explicitly.
    assign bus.Busy      = in_ready_d || wr_en_q;
    assign bus.WrEn      = wr_en_q;
    assign bus.WrAddr    = wr_addr_q;
    assign bus.WrData    = wr_data_q;
    assign bus.Done      = done_q;
    assign bus.Error     = error_q;
    assign bus.CpuHold   = cpu_hold_q;
    assign bus.WordCount = word_count_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: vector table, corner sequences, random frames.
module tb_instruction_loader;

    localparam int MEM  = 100;
    localparam int BASE = 0;

    logic CLK = 1'b0;
    logic Reset;

    always #5 CLK = ~CLK;

    instruction_loader_if #(.ADDR_W(32)) bus ();

    instruction_loader #(
        .MEM_BYTES(MEM),
        .BASE_ADDR(BASE),
        .ADDR_W   (32)
    ) dut (
        .CLK  (CLK),
        .Reset(Reset),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Write-port monitor: every cycle with WrEn high is one byte write.
    logic [31:0] wa_q[$];
    logic [7:0]  wd_q[$];
    always @(negedge CLK) begin
        if (bus.WrEn === 1'b1) begin
            wa_q.push_back(bus.WrAddr);
            wd_q.push_back(bus.WrData);
        end
    end

    logic [7:0] frm[$];

    task automatic pulse_start();
        @(posedge CLK);
        #1 bus.Start = 1'b1;
        @(posedge CLK);
        #1 bus.Start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap, input bit inj);
        int k;
        if (gap) begin
            bus.InValid = 1'b0;
            bus.Start   = inj;
            @(posedge CLK);
            #1 bus.Start = 1'b0;
        end
        bus.InByte  = b;
        bus.InValid = 1'b1;
        k = 0;
        @(negedge CLK);
        while (bus.InReady !== 1'b1 && k < 8) begin
            k++;
            @(negedge CLK);
        end
        check("in_ready", bus.InReady, 1);
        @(posedge CLK);
        #1 bus.InValid = 1'b0;
    endtask

    // Reference model: derive the expected writes and verdict straight from the frame bytes.
    task automatic run_frame(input string nm, input bit gaps, input bit inj,
                             output bit o_done, output bit o_err, output int o_nwr);
        int         len;
        bit         fault;
        int         nsend;
        int         nexp;
        logic [7:0] x;
        bit         exp_done;
        len      = {frm[0], frm[1]};
        fault    = (BASE + 4 * len) > MEM;
        nsend    = fault ? 2 : frm.size();
        nexp     = fault ? 0 : 4 * len;
        x        = 8'h00;
        exp_done = 1'b0;
        if (!fault) begin
            for (int i = 0; i < nexp; i++) x ^= frm[2 + i];
            exp_done = (frm[2 + nexp] == x);
        end
        wa_q.delete();
        wd_q.delete();
        pulse_start();
        for (int i = 0; i < nsend; i++) send_byte(frm[i], gaps, inj && (i == 4));
        @(negedge CLK);
        check({nm, "_done"},    bus.Done, exp_done);
        check({nm, "_error"},   bus.Error, !exp_done);
        check({nm, "_cpuhold"}, bus.CpuHold, !exp_done);
        check({nm, "_busy"},    bus.Busy, 0);
        check({nm, "_inready"}, bus.InReady, 0);
        check({nm, "_wc"},      bus.WordCount, len);
        check({nm, "_nwr"},     wa_q.size(), nexp);
        for (int i = 0; i < nexp && i < wa_q.size(); i++) begin
            check({nm, "_addr"}, wa_q[i], BASE + i);
            check({nm, "_data"}, wd_q[i], frm[2 + i]);
        end
        if (nexp > 0) begin
            check({nm, "_addr_hold"}, bus.WrAddr, BASE + nexp - 1);
            check({nm, "_data_hold"}, bus.WrData, frm[1 + nexp]);
        end
        o_done = bus.Done;
        o_err  = bus.Error;
        o_nwr  = wa_q.size();
    endtask

    typedef struct {
        string       name;
        logic [87:0] fb;     // frame bytes, right-aligned, first byte most significant
        int          n;
        bit          gaps;
        bit          inj;
        bit          done;
        bit          err;
        int          nwr;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         d;
        bit         e;
        int         nw;
        int         len;
        logic [7:0] x;

        tbl[0] = '{"good",      88'h00_02_20_08_00_05_01_09_50_20_55, 11, 0, 0, 1, 0, 8};
        tbl[1] = '{"badcsum",   88'h00_02_20_08_00_05_01_09_50_20_54, 11, 0, 0, 0, 1, 8};
        tbl[2] = '{"resend",    88'h00_02_20_08_00_05_01_09_50_20_55, 11, 0, 0, 1, 0, 8};
        tbl[3] = '{"oversize",  88'h00_1A,                            2,  0, 0, 0, 1, 0};
        tbl[4] = '{"gaps",      88'h00_02_20_08_00_05_01_09_50_20_55, 11, 1, 1, 1, 0, 8};
        tbl[5] = '{"zero",      88'h00_00_00,                         3,  0, 0, 1, 0, 0};
        tbl[6] = '{"zerobad",   88'h00_00_01,                         3,  0, 0, 0, 1, 0};

        Reset       = 1'b1;
        bus.Start   = 1'b0;
        bus.InByte  = 8'h00;
        bus.InValid = 1'b0;
        @(negedge CLK);
        check("rst_cpuhold", bus.CpuHold, 1);
        check("rst_wc", bus.WordCount, 0);
        check("rst_wraddr", bus.WrAddr, 0);
        check("rst_wrdata", bus.WrData, 0);
        @(posedge CLK);
        #1 Reset = 1'b0;
        // Idle outputs hold steady with InValid noise present.
        for (int c = 0; c < 10; c++) begin
            bus.InValid = c[0];
            @(negedge CLK);
            check("idle_outs", {bus.InReady, bus.Busy, bus.CpuHold, bus.WrEn, bus.Done, bus.Error},
                  6'b001000);
        end
        bus.InValid = 1'b0;
        check("idle_nwr", wa_q.size(), 0);

        // Vector table.
        for (int t = 0; t < 7; t++) begin
            frm.delete();
            for (int i = 0; i < tbl[t].n; i++) frm.push_back(tbl[t].fb[8 * (tbl[t].n - 1 - i) +: 8]);
            run_frame(tbl[t].name, tbl[t].gaps, tbl[t].inj, d, e, nw);
            check({tbl[t].name, "_tbl_done"}, d, tbl[t].done);
            check({tbl[t].name, "_tbl_err"}, e, tbl[t].err);
            check({tbl[t].name, "_tbl_nwr"}, nw, tbl[t].nwr);
        end

        // Largest frame that fits exactly: 25 words, last byte at address 99.
        frm.delete();
        frm.push_back(8'h00);
        frm.push_back(8'h19);
        x = 8'h00;
        for (int i = 0; i < 100; i++) begin
            frm.push_back(8'($urandom));
            x ^= frm[frm.size() - 1];
        end
        frm.push_back(x);
        run_frame("full", 0, 0, d, e, nw);
        check("full_done", d, 1);
        check("full_last_addr", wa_q.size() > 0 ? wa_q[wa_q.size() - 1] : 32'hFFFF_FFFF, 99);

        // Reset in the middle of the payload drops the write that was about to issue.
        frm.delete();
        frm = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00};
        wa_q.delete();
        wd_q.delete();
        pulse_start();
        for (int i = 0; i < 5; i++) send_byte(frm[i], 0, 0);
        Reset = 1'b1;
        @(negedge CLK);
        check("rstmid_wren", bus.WrEn, 0);
        check("rstmid_cpuhold", bus.CpuHold, 1);
        check("rstmid_busy", bus.Busy, 0);
        check("rstmid_inready", bus.InReady, 0);
        check("rstmid_done", bus.Done, 0);
        check("rstmid_nwr", wa_q.size(), 2);
        @(posedge CLK);
        #1 Reset = 1'b0;
        frm = '{8'h00, 8'h00, 8'h00};
        run_frame("after_rst", 0, 0, d, e, nw);
        check("after_rst_done", d, 1);
        check("after_rst_nwr", nw, 0);

        // Random frames, some oversize, some with a corrupted checksum.
        for (int r = 0; r < 25; r++) begin
            frm.delete();
            len = ($urandom_range(0, 9) == 0) ? 16'hFFFF : $urandom_range(0, 27);
            frm.push_back(8'(len >> 8));
            frm.push_back(8'(len));
            if (BASE + 4 * len <= MEM) begin
                x = 8'h00;
                for (int i = 0; i < 4 * len; i++) begin
                    frm.push_back(8'($urandom));
                    x ^= frm[frm.size() - 1];
                end
                if ($urandom_range(0, 3) == 0) x ^= 8'(1 << $urandom_range(0, 7));
                frm.push_back(x);
            end
            run_frame($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      d, e, nw);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
